// File: rtl/apb_master.sv
// APB requester: converts a valid/ready command stream into APB SETUP/ACCESS transfers
// and returns a one-cycle response pulse carrying read data, slave error or watchdog timeout.
module apb_master #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    localparam logic [7:0] WaitMax = 8'(TIMEOUT - 1);

    state_e                  state_q;
    logic [7:0]              wait_cnt_q;
    logic                    psel_q;
    logic                    penable_q;
    logic                    pwrite_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;
    logic                    rsp_timeout_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q       <= StIdle;
            wait_cnt_q    <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        pwrite_q  <= cmd_write;
                        paddr_q   <= cmd_addr;
                        pwdata_q  <= cmd_write ? cmd_wdata : '0;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= StSetup;
                    end
                end
                StSetup: begin
                    penable_q  <= 1'b1;
                    wait_cnt_q <= '0;
                    state_q    <= StAccess;
                end
                StAccess: begin
                    if (pready) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= pwrite_q ? '0 : prdata;
                        rsp_err_q     <= pslverr;
                        rsp_timeout_q <= 1'b0;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state_q       <= StIdle;
                    end else if (wait_cnt_q == WaitMax) begin
                        // Watchdog abort: the slave never answered within the budget.
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state_q       <= StIdle;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    assign cmd_ready   = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: scripted APB slave, reference memory model and a scoreboard that
// checks every response pulse (data, error, timeout, arrival cycle) plus APB signal stability.
module tb_apb_master;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    typedef struct {
        bit          w;
        logic [4:0]  a;
        logic [31:0] d;
        int          waits;
        bit          never;
        bit          err;
    } xfer_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        bit          to;
        longint      cyc;
    } exp_t;

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          busy;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;

    int     total = 0;
    int     bad = 0;
    longint cyc = 0;

    logic [31:0] ref_mem [32];
    logic [31:0] slv_mem [32];
    exp_t        exp_q[$];
    xfer_t       xq[$];

    apb_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .busy       (busy),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave model: pops the transfer profile at SETUP, inserts the scripted wait states.
    xfer_t cur;
    int    wcnt = 0;
    int    en_cnt = 0;
    bit    prev_psel = 1'b0;
    bit    prev_pen = 1'b0;

    always @(negedge pclk) begin
        if (!presetn) begin
            pready = 1'b0;
            prev_psel = 1'b0;
            prev_pen = 1'b0;
            en_cnt = 0;
            wcnt = 0;
        end else begin
            if (psel && !penable) begin
                chk("idle_gap_before_setup", 64'(prev_psel), 64'd0);
                if (xq.size() == 0) begin
                    chk("unexpected_setup", 64'd1, 64'd0);
                    cur = '{w: 1'b0, a: 5'd0, d: 32'd0, waits: 0, never: 1'b1, err: 1'b0};
                end else begin
                    cur = xq.pop_front();
                end
                wcnt = 0;
                en_cnt = 0;
                pready = 1'($urandom);
                prdata = $urandom;
                pslverr = 1'($urandom);
            end else if (psel && penable) begin
                en_cnt++;
                chk("apb_access_fields", {26'd0, pwrite, paddr, pwdata},
                    {26'd0, cur.w, cur.a, (cur.w ? cur.d : 32'd0)});
                if (!cur.never && wcnt == cur.waits) begin
                    pready = 1'b1;
                    prdata = pwrite ? $urandom : slv_mem[paddr];
                    pslverr = cur.err;
                    if (pwrite && !cur.err) slv_mem[paddr] = pwdata;
                end else begin
                    pready = 1'b0;
                    prdata = $urandom;
                    pslverr = 1'($urandom);
                    wcnt++;
                end
            end else begin
                if (prev_pen)
                    chk("penable_cycles", 64'(en_cnt), (cur.never ? 64'(TO) : 64'(cur.waits + 1)));
                pready = 1'($urandom);
                prdata = $urandom;
                pslverr = 1'($urandom);
            end
            prev_psel = psel;
            prev_pen = penable;
        end
    end

    // Response monitor: pops the scoreboard on every rsp_valid pulse.
    logic [31:0] last_rdata = '0;
    bit          last_err = 1'b0;
    bit          last_to = 1'b0;
    bit          prev_rv = 1'b0;

    always @(negedge pclk) begin
        exp_t e;
        if (!presetn) begin
            last_rdata = '0;
            last_err = 1'b0;
            last_to = 1'b0;
            prev_rv = 1'b0;
        end else if (rsp_valid) begin
            chk("rsp_valid_single_cycle", 64'(prev_rv), 64'd0);
            chk("idle_during_rsp", 64'(cmd_ready), 64'd1);
            if (exp_q.size() == 0) begin
                chk("spurious_rsp", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_fields", {30'd0, rsp_rdata, rsp_err, rsp_timeout},
                    {30'd0, e.rdata, e.err, e.to});
                chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
            end
            last_rdata = rsp_rdata;
            last_err = rsp_err;
            last_to = rsp_timeout;
            prev_rv = 1'b1;
        end else begin
            chk("rsp_hold", {30'd0, rsp_rdata, rsp_err, rsp_timeout},
                {30'd0, last_rdata, last_err, last_to});
            prev_rv = 1'b0;
        end
    end

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input bit w, input logic [4:0] a, input logic [31:0] d,
                         input int waits, input bit never, input bit err, input bit hold);
        int   n = 0;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 100) begin
            @(negedge pclk);
            n++;
        end
        if (n >= 100) begin
            chk("accept_wait_expired", 64'd1, 64'd0);
        end else begin
            if (never) begin
                e = '{rdata: 32'd0, err: 1'b1, to: 1'b1, cyc: cyc + 2 + longint'(TO)};
            end else begin
                e = '{rdata: (w ? 32'd0 : ref_mem[a]), err: err, to: 1'b0,
                      cyc: cyc + 3 + longint'(waits)};
                if (w && !err) ref_mem[a] = d;
            end
            exp_q.push_back(e);
            xq.push_back('{w: w, a: a, d: d, waits: waits, never: never, err: err});
        end
        @(negedge pclk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge pclk);
            n++;
        end
        if (n >= 200) chk("drain_expired", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge pclk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            ref_mem[i] = '0;
            slv_mem[i] = '0;
        end
        #1;
        chk("rst_ctrl", {56'd0, psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, busy,
            cmd_ready}, 64'h01);
        chk("rst_paddr_pwdata", {27'd0, paddr, pwdata}, 64'd0);
        chk("rst_rdata", 64'(rsp_rdata), 64'd0);
        repeat (3) @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);

        // Write then read through a RAM-like slave (one wait state).
        issue(1'b1, 5'd5, 32'hA5A5_0001, 1, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 5'd5, 32'hDEAD_BEEF, 1, 1'b0, 1'b0, 1'b0);
        drain();
        // Zero-wait read.
        issue(1'b1, 5'd3, 32'h1234_5678, 0, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 5'd3, 32'h0, 0, 1'b0, 1'b0, 1'b0);
        drain();
        // Three wait states then a slave error.
        issue(1'b1, 5'd9, 32'hCAFE_0009, 3, 1'b0, 1'b1, 1'b0);
        issue(1'b0, 5'd3, 32'h0, 3, 1'b0, 1'b1, 1'b0);
        drain();
        // Watchdog timeout, then a normal response clears rsp_timeout.
        issue(1'b0, 5'd7, 32'h0, 0, 1'b1, 1'b0, 1'b0);
        issue(1'b0, 5'd5, 32'h0, 0, 1'b0, 1'b0, 1'b0);
        drain();
        // Back-to-back writes with cmd_valid held, then read back.
        issue(1'b1, 5'd0, 32'h11, 1, 1'b0, 1'b0, 1'b1);
        issue(1'b1, 5'd1, 32'h22, 1, 1'b0, 1'b0, 1'b1);
        issue(1'b1, 5'd2, 32'h33, 1, 1'b0, 1'b0, 1'b1);
        issue(1'b0, 5'd0, 32'h0, 0, 1'b0, 1'b0, 1'b1);
        issue(1'b0, 5'd1, 32'h0, 0, 1'b0, 1'b0, 1'b1);
        issue(1'b0, 5'd2, 32'h0, 0, 1'b0, 1'b0, 1'b0);
        drain();

        for (int i = 0; i < 150; i++) begin
            bit hold;
            hold = 1'($urandom);
            issue(1'($urandom), 5'($urandom), $urandom, int'($urandom_range(0, 4)),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0), hold);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge pclk);
        end
        cmd_valid = 1'b0;
        drain();

        // Reset in the middle of ACCESS: no response, bus released at once.
        issue(1'b1, 5'd4, 32'h0BAD_F00D, 0, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge pclk);
        chk("in_access_before_rst", {62'd0, psel, penable}, 64'd3);
        #2 presetn = 1'b0;
        #1;
        chk("rst_async_drop", {62'd0, psel, penable}, 64'd0);
        exp_q.delete();
        xq.delete();
        repeat (2) @(negedge pclk);
        #2 presetn = 1'b1;
        @(negedge pclk);
        chk("ready_after_rst", {62'd0, cmd_ready, busy}, 64'd2);
        repeat (20) @(negedge pclk);
        issue(1'b0, 5'd5, 32'h0, 1, 1'b0, 1'b0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester: turns a simple valid/ready command interface into APB SETUP/ACCESS transfers.
- Drives APB slaves such as the team's 32-entry APB RAM.
- Returns read data, slave error and a watchdog-timeout indication as a one-cycle response pulse.
- Sits between a CPU/DMA-style command source and the APB slave interface.

Parameters:
- ADDR_WIDTH, 5: width of paddr and cmd_addr.
- DATA_WIDTH, 32: width of pwdata, prdata, cmd_wdata, rsp_rdata.
- TIMEOUT, 16: maximum ACCESS cycles before abort. Legal range 1..255.

Ports:
- pclk  input  1  APB clock, all logic on rising edge.
- presetn  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a pclk edge.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_WIDTH  transfer address.
- cmd_wdata  input  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  output  1  one-cycle response pulse; no backpressure.
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_err  output  1  pslverr sampled at completion, or timeout.
- rsp_timeout  output  1  transfer aborted by watchdog.
- busy  output  1  state != IDLE.
- psel, penable, pwrite  output  1 each  APB control.
- paddr  output  ADDR_WIDTH  APB address.
- pwdata  output  DATA_WIDTH  APB write data.
- prdata  input  DATA_WIDTH  APB read data.
- pready  input  1  APB ready.
- pslverr  input  1  APB slave error.

Behaviour:
- All outputs registered except cmd_ready and busy, which decode state combinationally.
- Reset values: state IDLE. psel, penable, pwrite, paddr, pwdata, rsp_* and the wait counter all 0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready = 1.
  - On accept, capture cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata. pwdata is forced to 0 for reads.
  - Next state SETUP, psel = 1, penable = 0.
- SETUP: lasts exactly one cycle. Next state ACCESS, penable = 1, wait counter cleared.
- ACCESS, at each edge:
  - pready = 1: capture rsp_rdata = (pwrite ? 0 : prdata) and rsp_err = pslverr. Pulse rsp_valid = 1 next cycle; psel = penable = 0; next state IDLE.
  - pready = 0 and counter == TIMEOUT-1: abort. psel = penable = 0; rsp_valid = 1, rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0; next state IDLE.
  - Otherwise: counter += 1, stay in ACCESS, paddr/pwrite/pwdata/psel/penable held stable.
- Latency (accept edge = edge 0):
  - SETUP during cycle 1, ACCESS from cycle 2.
  - Zero-wait slave: rsp_valid in cycle 3.
  - Team APB RAM (registered pready): rsp_valid in cycle 4.
- rsp_valid is high for exactly one cycle. rsp_rdata, rsp_err and rsp_timeout hold their values until the next response; rsp_timeout clears on the next normal response.
- Back-to-back: state is IDLE during the rsp_valid cycle, so a new command can be accepted there. Its SETUP starts the following cycle, giving at least one psel = 0 cycle between transfers.
- cmd_valid while busy is ignored (cmd_ready = 0). The command source holds it until accepted.
- paddr, pwrite and pwdata keep their last values in IDLE. Only psel and penable qualify them.
- prdata and pslverr are ignored unless pready = 1 in ACCESS.
- Reset mid-transfer: psel/penable drop asynchronously, no response is generated, and state returns to IDLE.

Test Plan:
1. Write then read with the APB RAM slave: write addr 5 data 0xA5A5_0001, then read addr 5. Expected: rsp_rdata = 0xA5A5_0001, rsp_err = 0. APB trace shows SETUP one cycle then ACCESS two cycles. rsp_valid arrives 4 cycles after each accept.
2. Zero-wait model slave (pready tied 1), read addr 3 returning 0x1234_5678. Expected: rsp_valid in cycle 3 after accept, rsp_rdata = 0x1234_5678.
3. Slave inserts 3 wait states then pready with pslverr = 1. Expected: paddr/pwdata stable for all 4 ACCESS cycles, rsp_err = 1, rsp_timeout = 0.
4. Slave never asserts pready, TIMEOUT = 16. Expected: penable high for exactly 16 cycles, then rsp_valid with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0, and the FSM returns to IDLE.
5. Back-to-back: cmd_valid held high for 3 writes (addr 0, 1, 2, data 0x11, 0x22, 0x33), then read back all three. Expected: one idle cycle between transfers, and read data matches.
6. presetn pulsed low during ACCESS. Expected: psel = penable = 0 immediately, no rsp_valid, and cmd_ready = 1 after reset release.
